// File: rtl/uart_word_loader.sv
// uart_word_loader: 8N1 UART receiver that packs bytes into words of
// WORD_BYTES bytes and emits them with an auto-incrementing byte address.
// Receiving the END_MARKER word stops loading until the next clear.
// Optional feature macro: UART_LOADER_TIMEOUT_EN enables flushing of a partial
// word after TIMEOUT_BITS bit times without a new byte.
`timescale 1ns/1ps
module uart_word_loader #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          WORD_BYTES   = 4,
  parameter int          ADDR_W       = 32,
  parameter bit          BIG_ENDIAN   = 1'b1,
  parameter logic [63:0] END_MARKER   = 64'h1111_1111_1111_1111,
  parameter int          TIMEOUT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx,
  input  logic                    clear,
  input  logic [ADDR_W-1:0]       start_addr,
  output logic                    byte_valid,
  output logic [7:0]              byte_data,
  output logic                    word_valid,
  output logic [WORD_BYTES*8-1:0] word_data,
  output logic [ADDR_W-1:0]       word_addr,
  output logic                    done,
  output logic                    frame_err,
  output logic                    timeout
);

  localparam int WORD_W = WORD_BYTES * 8;
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  HALF_C    = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_C     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [WORD_W-1:0] MARKER_C  = END_MARKER[WORD_W-1:0];

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Elaboration-time parameter legality checks.
  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_word_loader: CLKS_PER_BIT must be >= 4");
  end
  if (WORD_BYTES < 1 || WORD_BYTES > 8) begin : g_bad_wb
    $error("uart_word_loader: WORD_BYTES must be 1..8");
  end
  if (TIMEOUT_BITS < 1) begin : g_bad_tmo
    $error("uart_word_loader: TIMEOUT_BITS must be >= 1");
  end

  logic              sync1_r, rx_s;
  logic [2:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              byte_valid_r, frame_err_r;
  logic [7:0]        byte_data_r;
  logic [IDX_W-1:0]  idx_r;
  logic [WORD_W-1:0] part_r, next_part_s, word_data_r;
  logic [ADDR_W-1:0] word_addr_r;
  logic              word_valid_r, done_r;
  logic              accept_s, last_byte_s;

  // Two-flop synchroniser on the raw rx pin, idle-high reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= rx;
      rx_s    <= sync1_r;
    end
  end

  // RX framing FSM: start-bit check, 8 data bits LSB first, stop-bit check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (!rx_s) begin
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_r == HALF_C) begin
            cnt_r <= {CNT_W{1'b0}};
            if (rx_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r   <= ST_DATA;
              bit_idx_r <= 3'd0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_r == BIT_C) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {rx_s, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_r == BIT_C) begin
            cnt_r <= {CNT_W{1'b0}};
            if (rx_s) begin
              byte_valid_r <= 1'b1;
              byte_data_r  <= shift_r;
              state_r      <= ST_IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= ST_BREAK;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // A byte is accepted at the good stop sample; the assembler acts on the same
  // edge so word_valid lines up with that byte's byte_valid.
  assign accept_s    = (state_r == ST_STOP) && (cnt_r == BIT_C) && rx_s;
  assign last_byte_s = (idx_r == LAST_IDX);

  // Next partial word with the current byte placed in its lane.
  always_comb begin
    next_part_s = part_r;
    if (BIG_ENDIAN) begin
      next_part_s = (part_r << 8) | WORD_W'(shift_r);
    end else begin
      next_part_s[{idx_r, 3'b000} +: 8] = shift_r;
    end
  end

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TMO_W      = $clog2(TMO_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             timeout_r;
`endif

  // Word assembler, address counter, end-marker detection and session clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r        <= {IDX_W{1'b0}};
      part_r       <= {WORD_W{1'b0}};
      word_data_r  <= {WORD_W{1'b0}};
      word_addr_r  <= {ADDR_W{1'b0}};
      word_valid_r <= 1'b0;
      done_r       <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_cnt_r    <= {TMO_W{1'b0}};
      timeout_r    <= 1'b0;
`endif
    end else begin
      word_valid_r <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      timeout_r    <= 1'b0;
`endif
      if (clear) begin
        word_addr_r <= start_addr;
        done_r      <= 1'b0;
        idx_r       <= {IDX_W{1'b0}};
        part_r      <= {WORD_W{1'b0}};
`ifdef UART_LOADER_TIMEOUT_EN
        tmo_cnt_r   <= {TMO_W{1'b0}};
`endif
      end else begin
        // Address moves on only after the emitted word has been presented.
        if (word_valid_r) begin
          word_addr_r <= word_addr_r + ADDR_STEP;
        end
        if (accept_s && !done_r) begin
          if (last_byte_s) begin
            idx_r  <= {IDX_W{1'b0}};
            part_r <= {WORD_W{1'b0}};
            if (next_part_s == MARKER_C) begin
              done_r <= 1'b1;
            end else begin
              word_valid_r <= 1'b1;
              word_data_r  <= next_part_s;
            end
          end else begin
            idx_r  <= idx_r + IDX_W'(1);
            part_r <= next_part_s;
          end
        end
`ifdef UART_LOADER_TIMEOUT_EN
        // Inter-byte timer runs only while a partial word is pending.
        if (accept_s || (idx_r == {IDX_W{1'b0}})) begin
          tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (tmo_cnt_r == TMO_LAST) begin
          tmo_cnt_r <= {TMO_W{1'b0}};
          timeout_r <= 1'b1;
          idx_r     <= {IDX_W{1'b0}};
          part_r    <= {WORD_W{1'b0}};
        end else begin
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
`endif
      end
    end
  end

  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign word_valid = word_valid_r;
  assign word_data  = word_data_r;
  assign word_addr  = word_addr_r;
  assign done       = done_r;
  assign frame_err  = frame_err_r;
`ifdef UART_LOADER_TIMEOUT_EN
  assign timeout    = timeout_r;
`else
  assign timeout    = 1'b0;
`endif

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Parametrised UART program/data loader. Receives an 8N1 serial byte stream and packs bytes into words of configurable width and byte order. Each completed word is emitted with an auto-incrementing address, and an end-of-stream marker word stops loading. Sits between the board RX pin and the instruction/data memory write port of the core.

## Interface

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit; legal range ≥4.
- WORD_BYTES, 4: bytes per word; legal range 1..8.
- ADDR_W, 32: address width.
- BIG_ENDIAN, 1: 1 = first received byte lands in the MSB lane; 0 = first received byte lands in the LSB lane.
- END_MARKER, 64'h1111_1111_1111_1111: terminator word; only the low WORD_BYTES*8 bits are compared.
- TIMEOUT_BITS, 32: inter-byte timeout in bit times; used only with the macro.

Ports:
- Reset is reset_n, asynchronous, active-low; clock is clk.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx  in  1  asynchronous serial input, idle high.
- clear  in  1  single-cycle pulse: restart the load session.
- start_addr  in  ADDR_W  base address, loaded on clear.
- byte_valid  out  1  one-cycle pulse per accepted byte.
- byte_data  out  8  last accepted byte.
- word_valid  out  1  one-cycle pulse per completed word.
- word_data  out  WORD_BYTES*8  assembled word, valid while word_valid is high.
- word_addr  out  ADDR_W  byte address of the word's first byte.
- done  out  1  sticky; set when the end marker has been received.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- timeout  out  1  one-cycle pulse when a partial word is flushed.

## Operation

- Synchroniser: rx passes through 2 flops; both reset to 1 (idle).
- RX FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: a low synchronised rx moves to START and clears the bit-cycle counter.
  - START: at count CLKS_PER_BIT/2, sample rx. Low → DATA. High → IDLE (glitch rejected).
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then → STOP.
  - STOP: sample after CLKS_PER_BIT cycles. High → pulse byte_valid, → IDLE. Low → pulse frame_err, discard the byte, → BREAK.
  - BREAK: wait for rx high, then → IDLE.
- Assembler: keeps a byte index 0..WORD_BYTES-1.
  - BIG_ENDIAN=1: each byte shifts in from the LSB side.
  - BIG_ENDIAN=0: each byte is written to lane[index].
  - When the last byte is accepted, the index wraps to 0 and the word is compared with END_MARKER.
  - Word not equal to the marker: pulse word_valid. After emission, word_addr advances by WORD_BYTES, wrapping mod 2^ADDR_W.
  - Word equal to the marker: no word_valid, done=1, word_addr unchanged.
- While done=1, accepted bytes still pulse byte_valid but are not assembled.
- clear: loads word_addr ← start_addr, clears done, byte index and the partial word. It does not disturb the RX FSM.
  - If clear and byte_valid coincide, clear wins and the byte is not assembled (byte_valid still pulses).
- Reset values: byte_valid, word_valid, frame_err, timeout and done are 0; byte_data, word_data and word_addr are 0; FSM is in IDLE; byte index is 0.
- Reset asserted mid-frame aborts the frame. No byte is produced and no partial state is retained.

## Timing

- Falling edge on rx to START entry: 2 cycles (synchroniser).
- Start sample at START entry + CLKS_PER_BIT/2. Bit n (n = 0..7) is sampled at that point + (n+1)*CLKS_PER_BIT. The stop bit is sampled at + 9*CLKS_PER_BIT.
- byte_valid and byte_data are registered one cycle after the stop sample.
- word_valid is asserted in the same cycle as the byte_valid of the word's last byte, with word_data and word_addr stable in that cycle.
- frame_err is asserted in the cycle after the stop sample.
- Back-to-back frames (the next start bit immediately after the stop bit) are accepted without loss.

## Configuration

- UART_LOADER_TIMEOUT_EN defined:
  - A counter runs whenever the byte index is nonzero; any accepted byte restarts it.
  - On reaching TIMEOUT_BITS*CLKS_PER_BIT cycles: pulse timeout, discard the partial word, reset the byte index to 0. word_addr is unchanged.
- UART_LOADER_TIMEOUT_EN undefined: no counter logic; timeout is tied to 0 and partial words persist indefinitely.

## Test plan

Defaults: CLKS_PER_BIT=16, WORD_BYTES=4.
- clear with start_addr=0x100, send DE AD BE EF → 4 byte_valid pulses, one word_valid with word_data=0xDEADBEEF, word_addr=0x100.
- Send two words, then 11 11 11 11 → word_valid at addresses 0x100 and 0x104, none for the marker, done=1. A further 4 bytes give byte_valid only; a clear then resumes loading at start_addr.
- Frame byte 0x55 with its stop bit driven low → frame_err pulse, no byte_valid, byte index unchanged. The next good frame is received normally.
- rx low glitch of 5 cycles → no byte_valid, no frame_err, FSM back in IDLE.
- BIG_ENDIAN=0 instance, send 01 02 03 04 → word_data=0x04030201.
- UART_LOADER_TIMEOUT_EN with TIMEOUT_BITS=4: send 2 bytes, then idle for 80 cycles → one timeout pulse. The next 4 bytes form one word at the unchanged word_addr.
